// File: rtl/reg_rr_mux.sv
// reg_rr_mux: N-to-1 round-robin register-bus mux; optional stall timeout via REG_RR_MUX_TIMEOUT_EN
package reg_rr_mux_pkg;
    typedef struct packed {
        logic [31:0] addr;
        logic        write;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        logic        valid;
    } reg_req_t;
    typedef struct packed {
        logic [31:0] rdata;
        logic        error;
        logic        ready;
    } reg_rsp_t;
endpackage

module reg_rr_mux #(
    parameter int unsigned NoPorts       = 2,
    parameter type         req_t         = reg_rr_mux_pkg::reg_req_t,
    parameter type         rsp_t         = reg_rr_mux_pkg::reg_rsp_t,
    parameter int unsigned TimeoutCycles = 256,
    parameter int unsigned SelectWidth   = (NoPorts > 1) ? $clog2(NoPorts) : 1,
    parameter type         select_t      = logic [SelectWidth-1:0]
) (
    input  logic    clk_i,
    input  logic    rst_ni,
    input  req_t    in_req_i [NoPorts],
    output rsp_t    in_rsp_o [NoPorts],
    output req_t    out_req_o,
    input  rsp_t    out_rsp_i,
    output select_t sel_o,
    output logic    sel_valid_o
);
    if (NoPorts < 1) begin : g_bad_ports
        $fatal(1, "reg_rr_mux: NoPorts must be >= 1");
    end
    if (TimeoutCycles < 1) begin : g_bad_timeout
        $fatal(1, "reg_rr_mux: TimeoutCycles must be >= 1");
    end

    typedef enum logic {IDLE, BUSY} state_t;

    state_t      state_q, state_d;
    select_t     gnt_q, gnt_d, prio_q, prio_d;
    select_t     winner, g;
    logic        any_valid, act, busy, to;
    req_t        g_req;
    rsp_t        forced;
    int unsigned best_d, d;

    assign busy = (state_q == BUSY);

`ifdef REG_RR_MUX_TIMEOUT_EN
    logic [15:0] cnt_q;
    // stall counter restarts every time BUSY is entered
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) cnt_q <= '0;
        else         cnt_q <= busy ? cnt_q + 16'd1 : '0;
    end
    assign to = busy && (cnt_q == 16'(TimeoutCycles - 1));
`else
    assign to = 1'b0;
`endif

    // round-robin search: valid port with the smallest distance from prio_q wins
    always_comb begin
        winner    = '0;
        any_valid = 1'b0;
        best_d    = NoPorts;
        d         = 0;
        for (int unsigned j = 0; j < NoPorts; j++) begin
            d = (j >= 32'(prio_q)) ? j - 32'(prio_q) : j + NoPorts - 32'(prio_q);
            if (in_req_i[j].valid && d < best_d) begin
                best_d    = d;
                winner    = select_t'(j);
                any_valid = 1'b1;
            end
        end
        act = rst_ni && (busy || any_valid);
        g   = busy ? gnt_q : winner;
    end

    // request of the currently granted port, zero when nothing is granted
    always_comb begin
        g_req = '0;
        for (int unsigned j = 0; j < NoPorts; j++)
            if (act && g == select_t'(j)) g_req = in_req_i[j];
    end

    // state register: FSM, held grant and round-robin pointer
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            gnt_q   <= '0;
            prio_q  <= '0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            prio_q  <= prio_d;
        end
    end

    // next state: completion (or timeout) advances the pointer; a dropped valid does not
    always_comb begin
        state_d = busy ? ((g_req.valid && !out_rsp_i.ready && !to) ? BUSY : IDLE)
                       : ((act && !out_rsp_i.ready) ? BUSY : IDLE);
        gnt_d   = (!busy && act) ? winner : gnt_q;
        prio_d  = (act && g_req.valid && (out_rsp_i.ready || to))
                ? ((g == select_t'(NoPorts - 1)) ? '0 : g + select_t'(1)) : prio_q;
    end

    // outputs: forward granted request, route response back, force error on timeout
    always_comb begin
        forced       = '0;
        forced.error = 1'b1;
        forced.ready = 1'b1;
        out_req_o       = g_req;
        out_req_o.valid = g_req.valid && !to;
        for (int unsigned j = 0; j < NoPorts; j++)
            in_rsp_o[j] = (act && g == select_t'(j)) ? (to ? forced : out_rsp_i) : '0;
        sel_o       = act ? g : '0;
        sel_valid_o = act;
    end
endmodule

// File: tb/tb_reg_rr_mux.sv
// tb_reg_rr_mux: directed checks of arbitration, hold, routing, reset and stall behaviour
module tb_reg_rr_mux;
    import reg_rr_mux_pkg::*;

    logic     clk = 1'b0;
    logic     rst_n = 1'b0;
    reg_req_t in_req [3];
    reg_rsp_t in_rsp [3];
    reg_req_t out_req;
    reg_rsp_t out_rsp;
    logic [1:0] sel;
    logic     sel_valid;
    int       total = 0;
    int       bad = 0;
    reg_req_t r0, r1, r2;
    reg_rsp_t e;
    int       ord [4] = '{0, 1, 2, 0};

    always #5 clk = ~clk;

`ifdef REG_RR_MUX_TIMEOUT_EN
    reg_rr_mux #(.NoPorts(3), .TimeoutCycles(8)) dut (
`else
    reg_rr_mux #(.NoPorts(3)) dut (
`endif
        .clk_i(clk), .rst_ni(rst_n), .in_req_i(in_req), .in_rsp_o(in_rsp),
        .out_req_o(out_req), .out_rsp_i(out_rsp), .sel_o(sel), .sel_valid_o(sel_valid)
    );

    function automatic reg_req_t mk(input logic [31:0] a, input logic w, input logic [31:0] dat);
        reg_req_t r;
        r.addr  = a;
        r.write = w;
        r.wdata = dat;
        r.wstrb = 4'hf;
        r.valid = 1'b1;
        return r;
    endfunction

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clr();
        for (int i = 0; i < 3; i++) in_req[i] = '0;
        out_rsp = '0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        clr();
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    initial begin
        r0 = mk(32'h0, 1'b1, 32'h1111_0000);
        r1 = mk(32'h10, 1'b1, 32'hA5A5_5A5A);
        r2 = mk(32'h30, 1'b0, 32'h0);
        clr();
        in_req[0] = r0;
        out_rsp.ready = 1'b1;
        #3;
        chk("rst_out_req", 128'(out_req), 128'(0));
        chk("rst_sel_valid", 128'(sel_valid), 128'(0));
        chk("rst_sel", 128'(sel), 128'(0));
        chk("rst_rsp0", 128'(in_rsp[0]), 128'(0));
        tick();
        rst_n = 1'b1;
        clr();
        // single port, zero-wait target
        tick();
        in_req[1] = r1;
        out_rsp.ready = 1'b1;
        #1;
        chk("t1_out_req", 128'(out_req), 128'(r1));
        chk("t1_rsp1_ready", 128'(in_rsp[1].ready), 128'(1));
        chk("t1_rsp0", 128'(in_rsp[0]), 128'(0));
        chk("t1_sel", 128'(sel), 128'(1));
        chk("t1_sel_valid", 128'(sel_valid), 128'(1));
        tick();
        clr();
        in_req[0] = r0;
        in_req[2] = r2;
        out_rsp.ready = 1'b1;
        #1;
        chk("t1_prio2", 128'(sel), 128'(2));
        tick();
        #1;
        chk("t1_wrap0", 128'(sel), 128'(0));
        tick();
        #1;
        chk("t1_skip1", 128'(sel), 128'(2));
        tick();
        clr();
        #1;
        chk("t1_idle_valid", 128'(sel_valid), 128'(0));
        chk("t1_idle_req", 128'(out_req), 128'(0));
        // all ports requesting, zero-wait target
        do_reset();
        in_req[0] = r0;
        in_req[1] = r1;
        in_req[2] = r2;
        out_rsp.ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            if (k > 0) tick();
            #1;
            chk("t2_order", 128'(sel), 128'(ord[k]));
            for (int j = 0; j < 3; j++)
                chk("t2_ready", 128'(in_rsp[j].ready), 128'(j == ord[k]));
        end
        // grant held through a 5-cycle stall
        tick();
        clr();
        in_req[0] = r0;
        #1;
        chk("t3_sel_c1", 128'(sel), 128'(0));
        chk("t3_req_c1", 128'(out_req), 128'(r0));
        for (int c = 2; c <= 6; c++) begin
            tick();
            if (c == 2) in_req[2] = r2;
            if (c == 6) out_rsp.ready = 1'b1;
            #1;
            chk("t3_req_hold", 128'(out_req), 128'(r0));
            chk("t3_sel_hold", 128'(sel), 128'(0));
            chk("t3_rsp2_zero", 128'(in_rsp[2]), 128'(0));
        end
        chk("t3_done_ready", 128'(in_rsp[0].ready), 128'(1));
        tick();
        in_req[0] = '0;
        out_rsp = '0;
        #1;
        chk("t3_next_sel", 128'(sel), 128'(2));
        chk("t3_next_req", 128'(out_req), 128'(r2));
        // error response routed unchanged
        tick();
        out_rsp.rdata = 32'hDEAD_BEEF;
        out_rsp.error = 1'b1;
        out_rsp.ready = 1'b1;
        e.rdata = 32'hDEAD_BEEF;
        e.error = 1'b1;
        e.ready = 1'b1;
        #1;
        chk("t4_rsp2", 128'(in_rsp[2]), 128'(e));
        chk("t4_rsp0", 128'(in_rsp[0]), 128'(0));
        // async reset while BUSY on port1
        tick();
        clr();
        in_req[1] = r1;
        #1;
        chk("t5_grant1", 128'(sel), 128'(1));
        tick();
        in_req[0] = r0;
        #1;
        chk("t5_busy_hold", 128'(sel), 128'(1));
        rst_n = 1'b0;
        #1;
        chk("t5_rst_req", 128'(out_req), 128'(0));
        chk("t5_rst_valid", 128'(sel_valid), 128'(0));
        chk("t5_rst_rsp1", 128'(in_rsp[1]), 128'(0));
        rst_n = 1'b1;
        #1;
        chk("t5_post_sel", 128'(sel), 128'(0));
        chk("t5_post_valid", 128'(sel_valid), 128'(1));
        // target never ready
        do_reset();
        in_req[0] = r0;
        in_req[1] = r1;
        #1;
        chk("t6_sel", 128'(sel), 128'(0));
`ifdef REG_RR_MUX_TIMEOUT_EN
        for (int k = 1; k <= 7; k++) begin
            tick();
            #1;
            chk("t6_stall_ready", 128'(in_rsp[0].ready), 128'(0));
        end
        tick();
        e = '0;
        e.error = 1'b1;
        e.ready = 1'b1;
        #1;
        chk("t6_forced_rsp", 128'(in_rsp[0]), 128'(e));
        chk("t6_forced_valid", 128'(out_req.valid), 128'(0));
        tick();
        #1;
        chk("t6_after_sel", 128'(sel), 128'(1));
`else
        repeat (1000) tick();
        #1;
        chk("t6_still_valid", 128'(sel_valid), 128'(1));
        chk("t6_still_sel", 128'(sel), 128'(0));
        chk("t6_still_req", 128'(out_req), 128'(r0));
        chk("t6_rsp1", 128'(in_rsp[1]), 128'(0));
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
